crc16_gen: RTL and testbench

//  Transmit-side CRC16 generator; counterpart of the crc16_chk receive checker.

---
 rtl/crc16_gen.sv | 116 +++++++++++
 tb/tb_crc16_gen.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc16_gen.sv
// crc16_gen
//   Transmit-side CRC16 generator. A 64-bit word is accepted on crc16_start.
//   Its CRC16 is computed one byte per clock, most significant byte first,
//   over 8 cycles. The result is returned alone on crc16_O and as the 80-bit
//   frame {data, crc} on crc16_DO for the serial transmit path.
//
// Parameters
//   POLY    generator polynomial, normal (non-reflected) form
//   INIT    CRC register preset at the start of each word
//   XOROUT  value XORed into the final CRC before output
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   crc16_start  compute the CRC of crc16_DI (honoured only in IDLE)
//   crc16_clear  synchronous abort back to IDLE, has priority over start
//   crc16_DI     64-bit data word, valid with crc16_start
//   crc16_busy   high while a word is in CALC or DONE
//   crc16_done   one-cycle pulse, crc16_O / crc16_DO freshly valid
//   crc16_O      computed CRC, held until the next done or reset
//   crc16_DO     frame {latched data, crc16_O}, held like crc16_O
module crc16_gen #(
  parameter logic [15:0] POLY   = 16'h1021,
  parameter logic [15:0] INIT   = 16'hFFFF,
  parameter logic [15:0] XOROUT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        crc16_start,
  input  logic        crc16_clear,
  input  logic [63:0] crc16_DI,
  output logic        crc16_busy,
  output logic        crc16_done,
  output logic [15:0] crc16_O,
  output logic [79:0] crc16_DO
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_next;
  logic [63:0] data_reg;
  logic [15:0] crc_reg;
  logic [15:0] crc_step;
  logic [2:0]  cnt;
  logic [5:0]  byte_base;
  logic [7:0]  cur_byte;
  logic        accept;

  // One byte of the MSB-first CRC: fold the byte into the top of the
  // register, then run eight polynomial-division shift steps.
  function automatic logic [15:0] crc_byte(input logic [15:0] crc_in,
                                           input logic [7:0]  b);
    logic [15:0] c;
    c = crc_in ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ({c[14:0], 1'b0} ^ POLY) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // Byte cnt occupies bits [63-8*cnt -: 8]. For a 3-bit count, ~cnt equals
  // 7-cnt, so the low bit of that byte is {~cnt, 3'b000}.
  assign byte_base = {~cnt, 3'b000};
  assign cur_byte  = data_reg[byte_base +: 8];
  assign crc_step  = crc_byte(crc_reg, cur_byte);

  // A start is taken only from IDLE, and clear always wins over it.
  assign accept = (state == IDLE) && crc16_start && !crc16_clear;

  assign crc16_busy = (state != IDLE);
  assign crc16_done = (state == DONE);

  // Next-state logic. DONE always lasts exactly one cycle, so any start
  // seen while in DONE is dropped.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = CALC;
      CALC: begin
        if (crc16_clear)      state_next = IDLE;
        else if (cnt == 3'd7) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and datapath. crc16_O and crc16_DO change only when the
  // last byte completes. An abort or reset therefore never exposes a
  // partial CRC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      data_reg <= '0;
      crc_reg  <= '0;
      cnt      <= '0;
      crc16_O  <= '0;
      crc16_DO <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        data_reg <= crc16_DI;
        crc_reg  <= INIT;
        cnt      <= '0;
      end else if (state == CALC && !crc16_clear) begin
        crc_reg <= crc_step;
        cnt     <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          crc16_O  <= crc_step ^ XOROUT;
          crc16_DO <= {data_reg, crc_step ^ XOROUT};
        end
      end
    end
  end

endmodule

// File: tb/tb_crc16_gen.sv
// tb_crc16_gen
//   Self-checking bench for crc16_gen. Two instances share the same stimulus.
//   Instance a uses INIT=0, so results can be compared against known
//   constants. Instance b uses the default parameters. A bit-serial
//   reference model pushes expected results into a scoreboard when a start
//   is accepted. A monitor pops them when done fires.
module tb_crc16_gen;

  localparam logic [15:0] POLY = 16'h1021;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [63:0] data  = '0;

  logic        busy_a, done_a, busy_b, done_b;
  logic [15:0] o_a, o_b;
  logic [79:0] do_a, do_b;

  crc16_gen #(.POLY(16'h1021), .INIT(16'h0000), .XOROUT(16'h0000)) dut_a (
    .clk(clk), .rst(rst), .crc16_start(start), .crc16_clear(clear),
    .crc16_DI(data), .crc16_busy(busy_a), .crc16_done(done_a),
    .crc16_O(o_a), .crc16_DO(do_a)
  );

  crc16_gen dut_b (
    .clk(clk), .rst(rst), .crc16_start(start), .crc16_clear(clear),
    .crc16_DI(data), .crc16_busy(busy_b), .crc16_done(done_b),
    .crc16_O(o_b), .crc16_DO(do_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [15:0] crc_a;
    logic [15:0] crc_b;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        new_exp;
  exp_t        got;
  int          checks = 0;
  int          fails = 0;
  int          cycle = 0;
  int          m_left = 0;
  int          done_count = 0;
  int          prev_done_cycle = -1;
  int          last_done_cycle = -1;
  logic [15:0] last_crc_a = '0;

  // Bit-serial reference: processes the low nbits of v, MSB first.
  function automatic logic [15:0] crc_bits(input logic [15:0] init,
                                           input logic [79:0] v,
                                           input int          nbits);
    logic [15:0] c;
    logic        fb;
    c = init;
    for (int i = nbits - 1; i >= 0; i--) begin
      fb = c[15] ^ v[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ POLY;
    end
    return c;
  endfunction

  // Acceptance model. A word keeps the block busy for 9 edges after its
  // start edge. A clear during that time cancels the word.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left = 0;
      sb.delete();
    end else begin
      cycle++;
      if (m_left == 0) begin
        if (!clear && start) begin
          new_exp.data  = data;
          new_exp.crc_a = crc_bits(16'h0000, {16'h0, data}, 64);
          new_exp.crc_b = crc_bits(16'hFFFF, {16'h0, data}, 64);
          new_exp.due   = cycle + 8;
          sb.push_back(new_exp);
          m_left = 9;
        end
      end else if (clear) begin
        m_left = 0;
        sb.delete();
      end else begin
        m_left--;
      end
    end
  end

  // Monitor: on the falling edge, check that done appears exactly when the
  // oldest expected word is due, and that it carries the right CRC/frame.
  always @(negedge clk) begin
    if (rst) begin
      if (done_a === 1'b1) begin
        done_count++;
        prev_done_cycle = last_done_cycle;
        last_done_cycle = cycle;
      end
      if (sb.size() > 0 && cycle >= sb[0].due) begin
        got = sb.pop_front();
        last_crc_a = got.crc_a;
        checks++;
        if (done_a !== 1'b1 || done_b !== 1'b1) begin
          fails++;
          $display("[TB] FAIL done_at_due cycle %0d: done_a=%b done_b=%b required 1", cycle, done_a, done_b);
        end
        checks++;
        if (o_a !== got.crc_a) begin
          fails++;
          $display("[TB] FAIL crc_a: got %h required %h", o_a, got.crc_a);
        end
        checks++;
        if (do_a !== {got.data, got.crc_a}) begin
          fails++;
          $display("[TB] FAIL frame_a: got %h required %h", do_a, {got.data, got.crc_a});
        end
        checks++;
        if (o_b !== got.crc_b) begin
          fails++;
          $display("[TB] FAIL crc_b: got %h required %h", o_b, got.crc_b);
        end
        checks++;
        if (do_b !== {got.data, got.crc_b}) begin
          fails++;
          $display("[TB] FAIL frame_b: got %h required %h", do_b, {got.data, got.crc_b});
        end
      end else if (done_a !== 1'b0 || done_b !== 1'b0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_done cycle %0d: done_a=%b done_b=%b required 0", cycle, done_a, done_b);
      end
    end
  end

  // Issue one word, then wait until the block is idle again.
  task automatic send_word(input logic [63:0] d);
    @(negedge clk);
    data  = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_busy: got %b/%b required 0", busy_a, busy_b);
    end
    checks++;
    if (done_a !== 1'b0 || done_b !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_done: got %b/%b required 0", done_a, done_b);
    end
    checks++;
    if (o_a !== 16'h0000 || o_b !== 16'h0000) begin
      fails++;
      $display("[TB] FAIL reset_crc: got %h/%h required 0000", o_a, o_b);
    end
    checks++;
    if (do_a !== 80'h0 || do_b !== 80'h0) begin
      fails++;
      $display("[TB] FAIL reset_frame: got %h/%h required 0", do_a, do_b);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Known-answer words, checked on the INIT=0 instance.
  task automatic test_known_values;
    logic [63:0] kv_data [3];
    logic [15:0] kv_crc  [3];
    kv_data[0] = 64'h1;   kv_crc[0] = 16'h1021;
    kv_data[1] = 64'h2;   kv_crc[1] = 16'h2042;
    kv_data[2] = 64'h100; kv_crc[2] = 16'h3331;
    for (int i = 0; i < 3; i++) begin
      send_word(kv_data[i]);
      checks++;
      if (o_a !== kv_crc[i]) begin
        fails++;
        $display("[TB] FAIL known_crc[%0d]: got %h required %h", i, o_a, kv_crc[i]);
      end
      checks++;
      if (do_a !== {kv_data[i], kv_crc[i]}) begin
        fails++;
        $display("[TB] FAIL known_frame[%0d]: got %h required %h", i, do_a, {kv_data[i], kv_crc[i]});
      end
      checks++;
      if (busy_a !== 1'b0) begin
        fails++;
        $display("[TB] FAIL known_idle[%0d]: busy got %b required 0", i, busy_a);
      end
    end
  endtask

  // With XOROUT=0, recomputing over the whole frame must give zero residue.
  task automatic test_residue;
    logic [15:0] r;
    send_word(64'hFFFF_FFFF_FFFF_FFFF);
    r = crc_bits(16'hFFFF, do_b, 80);
    checks++;
    if (r !== 16'h0000) begin
      fails++;
      $display("[TB] FAIL residue_b: got %h required 0000", r);
    end
    r = crc_bits(16'h0000, do_a, 80);
    checks++;
    if (r !== 16'h0000) begin
      fails++;
      $display("[TB] FAIL residue_a: got %h required 0000", r);
    end
  endtask

  task automatic test_reset_mid_calc;
    int dc0;
    dc0 = done_count;
    @(negedge clk);
    data  = 64'hDEAD_BEEF_0123_4567;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midreset_ctrl: busy=%b done=%b required 0/0", busy_a, done_a);
    end
    checks++;
    if (o_a !== 16'h0000 || o_b !== 16'h0000 || do_b !== 80'h0) begin
      fails++;
      $display("[TB] FAIL midreset_out: got %h/%h required 0000", o_a, o_b);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (done_count !== dc0) begin
      fails++;
      $display("[TB] FAIL midreset_nodone: done pulses %0d required 0", done_count - dc0);
    end
  endtask

  // A start held high across two words: the start seen in DONE is dropped,
  // so the second word begins one edge later.
  task automatic test_start_held;
    int dc0;
    dc0 = done_count;
    @(negedge clk);
    data  = {$urandom, $urandom};
    start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (done_count - dc0 !== 2) begin
      fails++;
      $display("[TB] FAIL held_count: got %0d pulses required 2", done_count - dc0);
    end
    checks++;
    if (last_done_cycle - prev_done_cycle !== 10) begin
      fails++;
      $display("[TB] FAIL held_spacing: got %0d required 10", last_done_cycle - prev_done_cycle);
    end
  endtask

  task automatic test_clear;
    int          dc0;
    logic [15:0] o_prev;
    send_word(64'h0011_2233_4455_6677);
    o_prev = last_crc_a;
    dc0    = done_count;
    @(negedge clk);
    data  = 64'h8899_AABB_CCDD_EEFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      fails++;
      $display("[TB] FAIL clear_ctrl: busy=%b done=%b required 0/0", busy_a, done_a);
    end
    checks++;
    if (o_a !== o_prev) begin
      fails++;
      $display("[TB] FAIL clear_hold: got %h required %h", o_a, o_prev);
    end
    // clear together with start while idle must not begin a word
    clear = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    checks++;
    if (busy_a !== 1'b0) begin
      fails++;
      $display("[TB] FAIL clear_idle_start: busy got %b required 0", busy_a);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (done_count !== dc0) begin
      fails++;
      $display("[TB] FAIL clear_nodone: got %0d pulses required 0", done_count - dc0);
    end
    send_word(64'h8899_AABB_CCDD_EEFF);
    checks++;
    if (done_count - dc0 !== 1) begin
      fails++;
      $display("[TB] FAIL clear_restart: got %0d pulses required 1", done_count - dc0);
    end
  endtask

  // Random words started at the earliest edge the block will take them.
  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data  = {$urandom, $urandom};
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin
      fails++;
      $display("[TB] FAIL b2b_drain: %0d words outstanding required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_known_values();
    test_residue();
    test_reset_mid_calc();
    test_start_held();
    test_clear();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
